// File: rtl/window_mac_pkg.sv
// Shared types and helpers for the windowed multiply-accumulate block.
package window_mac_pkg;

  // Internal width used for the saturating add; wide enough for any
  // accumulator up to 62 bits plus a shifted product without wrap.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] sum;
    logic                    ovf;
  } sat_res_t;

  // Left shift that aligns a product (2*frac_in fractional bits) to the
  // result format (frac_out fractional bits).
  function automatic int frac_shift(input int frac_out, input int frac_in);
    return frac_out - 2 * frac_in;
  endfunction

  // Add two values and clamp the result to a signed range of 'width' bits.
  // The inputs must already lie inside that range, so one extra bit of
  // headroom is all the add needs; the wide internal width provides it.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] acc,
                                       input logic signed [SAT_W-1:0] addend,
                                       input int                      width);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_res_t                r;
    s     = acc + addend;
    max_v = $signed((64'd1 << (width - 1)) - 64'd1);
    min_v = ~max_v;
    r.sum = s;
    r.ovf = 1'b0;
    if (s > max_v) begin
      r.sum = max_v;
      r.ovf = 1'b1;
    end else if (s < min_v) begin
      r.sum = min_v;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/window_mac_if.sv
// Sample input and result output handshakes of window_mac.
interface window_mac_if #(
  parameter int channels_p  = 2,
  parameter int width_in_p  = 12,
  parameter int width_out_p = 32
);
  logic                              clear_i;
  logic [channels_p*width_in_p-1:0]  a_i;
  logic [channels_p*width_in_p-1:0]  b_i;
  logic                              valid_i;
  logic                              ready_o;
  logic [channels_p*width_out_p-1:0] data_o;
  logic [channels_p-1:0]             overflow_o;
  logic                              valid_o;
  logic                              ready_i;

  // Block side
  modport slave (
    input  clear_i, a_i, b_i, valid_i, ready_i,
    output ready_o, data_o, overflow_o, valid_o
  );

  // Producer/consumer side
  modport master (
    output clear_i, a_i, b_i, valid_i, ready_i,
    input  ready_o, data_o, overflow_o, valid_o
  );
endinterface

// File: rtl/window_mac_mac_lane.sv
// One lane: product register, saturating accumulator, sticky overflow
// and the lane's slice of the result register.
module mac_lane
  import window_mac_pkg::*;
#(
  parameter int width_in_p  = 12,
  parameter int frac_in_p   = 11,
  parameter int width_out_p = 32,
  parameter int frac_out_p  = 22
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          clear_i,
  input  logic                          load_i,    // sample accepted into stage 1
  input  logic                          acc_en_i,  // stage 1 advances into accumulator
  input  logic                          last_i,    // advancing sample closes the window
  input  logic signed [width_in_p-1:0]  a_i,
  input  logic signed [width_in_p-1:0]  b_i,
  output logic signed [width_out_p-1:0] data_o,
  output logic                          overflow_o
);

  localparam int PW = 2 * width_in_p;
  localparam int SH = frac_shift(frac_out_p, frac_in_p);

  logic signed [PW-1:0]          prod_q, prod_d;
  logic signed [width_out_p-1:0] acc_q, acc_d;
  logic signed [width_out_p-1:0] res_q, res_d;
  logic                          ovf_q, ovf_d;
  logic                          res_ovf_q, res_ovf_d;
  logic signed [SAT_W-1:0]       addend;
  sat_res_t                      sat;

  // Stage 1: full-precision product of the accepted sample
  always_comb begin
    prod_d = prod_q;
    if (clear_i)     prod_d = '0;
    else if (load_i) prod_d = PW'(a_i) * PW'(b_i);
  end

  // Stage 2: align product to the result format and saturate into the sum
  always_comb begin
    addend = SAT_W'(prod_q) <<< SH;
    sat    = sat_add(SAT_W'(acc_q), addend, width_out_p);
  end

  // Accumulator and sticky flag; window end restarts both from zero
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (acc_en_i) begin
      if (last_i) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = sat.sum[width_out_p-1:0];
        ovf_d = ovf_q | sat.ovf;
      end
    end
  end

  // Result slice captures the closing sum; untouched by clear
  always_comb begin
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    if (last_i) begin
      res_d     = sat.sum[width_out_p-1:0];
      res_ovf_d = ovf_q | sat.ovf;
    end
  end

  // Lane state registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prod_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign data_o     = res_q;
  assign overflow_o = res_ovf_q;

endmodule

// File: rtl/window_mac.sv
// Multi-channel windowed multiply-accumulate: shared sample counter,
// stage-1 control, stall and result valid; per-lane datapath in mac_lane.
module window_mac
  import window_mac_pkg::*;
#(
  parameter int channels_p   = 2,
  parameter int width_in_p   = 12,
  parameter int frac_in_p    = 11,
  parameter int width_out_p  = 32,
  parameter int frac_out_p   = 22,
  parameter int window_len_p = 44100
) (
  input logic          clk_i,
  input logic          reset_n_i,
  window_mac_if.slave  bus
);

  localparam int            CW       = (window_len_p > 1) ? $clog2(window_len_p) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(window_len_p - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_last_q, s1_last_d;
  logic          valid_q, valid_d;

  logic stall, ready, accept, acc_en, win_end;

  logic [channels_p-1:0][width_out_p-1:0] lane_data;
  logic [channels_p-1:0]                  lane_ovf;

  // A closing sample may not overwrite a result the consumer has not taken
  always_comb begin
    stall   = s1_valid_q & s1_last_q & valid_q & ~bus.ready_i;
    ready   = ~stall & ~bus.clear_i;
    accept  = bus.valid_i & ready;
    acc_en  = s1_valid_q & ~stall & ~bus.clear_i;
    win_end = acc_en & s1_last_q;
  end

  // Sample counter and stage-1 valid/last tracking
  always_comb begin
    cnt_d      = cnt_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    if (bus.clear_i) begin
      cnt_d      = '0;
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
    end else if (accept) begin
      cnt_d      = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
      s1_valid_d = 1'b1;
      s1_last_d  = (cnt_q == LAST_CNT);
    end else if (!stall) begin
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
    end
  end

  // Result valid: a new load wins over a same-cycle drain
  always_comb begin
    valid_d = valid_q;
    if (win_end)                  valid_d = 1'b1;
    else if (valid_q & bus.ready_i) valid_d = 1'b0;
  end

  // Control registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      valid_q    <= valid_d;
    end
  end

  for (genvar k = 0; k < channels_p; k++) begin : g_lane
    mac_lane #(
      .width_in_p (width_in_p),
      .frac_in_p  (frac_in_p),
      .width_out_p(width_out_p),
      .frac_out_p (frac_out_p)
    ) u_lane (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (bus.clear_i),
      .load_i    (accept),
      .acc_en_i  (acc_en),
      .last_i    (win_end),
      .a_i       (bus.a_i[k*width_in_p +: width_in_p]),
      .b_i       (bus.b_i[k*width_in_p +: width_in_p]),
      .data_o    (lane_data[k]),
      .overflow_o(lane_ovf[k])
    );
  end

  assign bus.ready_o    = ready;
  assign bus.valid_o    = valid_q;
  assign bus.data_o     = lane_data;
  assign bus.overflow_o = lane_ovf;

endmodule

// File: doc/window_mac.md
# window_mac

Multi-channel windowed multiply-accumulate for the audio path. It correlates two sample streams, such as a generated reference tone and line-in audio, over a fixed window of `window_len_p` accepted samples per channel. At the end of each window it emits one saturated fixed-point sum per channel on a ready/valid output, and it restarts the next window with no dropped samples. It sits between the deserialiser output and a result consumer (display or logger) and runs in the main audio clock domain.

## Interface
Parameters:
- `channels_p`, 2, number of independent lanes.
- `width_in_p`, 12, signed width of each `a`/`b` sample.
- `frac_in_p`, 11, fractional bits of each input.
- `width_out_p`, 32, signed accumulator/result width.
- `frac_out_p`, 22, fractional bits of the result; must satisfy `frac_out_p >= 2*frac_in_p`.
- `window_len_p`, 44100, samples per window; must be >= 1.

Ports:
- `clk_i`, in, 1, sole clock.
- `reset_n_i`, in, 1, reset; asynchronous, active-low.
- `clear_i`, in, 1, synchronous abort of the current window.
- `a_i`, in, `channels_p*width_in_p`, lane k at `[k*width_in_p +: width_in_p]`, signed.
- `b_i`, in, `channels_p*width_in_p`, same packing, signed.
- `valid_i`, in, 1, `a_i`/`b_i` valid.
- `ready_o`, out, 1, sample accepted when `valid_i & ready_o`.
- `data_o`, out, `channels_p*width_out_p`, per-lane window sum, signed.
- `overflow_o`, out, `channels_p`, per-lane saturation occurred during the window.
- `valid_o`, out, 1, result valid.
- `ready_i`, in, 1, consumer accepts result when `valid_o & ready_i`.

## Operation
- **Stage 1 (multiply):** on accept, register per-lane product `a*b` (2*`width_in_p` bits, frac 2*`frac_in_p`). Also register an `s1_last` flag, set when the sample counter equals `window_len_p-1`.
- **Sample counter:**
  - Width is `$clog2(window_len_p)` (min 1).
  - Increments on accept.
  - Wraps to 0 after `window_len_p-1`.
- **Stage 2 (accumulate):**
  - Sign-extend the product and shift it left by `frac_out_p-2*frac_in_p`.
  - Add it to the accumulator in `width_out_p+1` bits.
  - Saturate to the `width_out_p` signed range. On saturation, set that lane's sticky overflow flag.
- **Window end (`s1_last` advancing):**
  - The saturated sum and overflow flags load the result register.
  - `valid_o` is set.
  - Accumulators and flags go to 0, so the next sample starts the new window fresh.
- **Result register:** holds until `valid_o & ready_i`; `valid_o` clears on that handshake unless a new result loads in the same cycle.
- **Stall:** `stall = s1_valid & s1_last & valid_o & ~ready_i`.
  - While stalled, stage 1 holds.
  - `ready_o = ~stall & ~clear_i`.
- **clear_i:**
  - Zeroes the counter, accumulators and flags, and drops the stage-1 contents.
  - `ready_o` is 0, so no sample is accepted that cycle.
  - The result register, `valid_o` and `overflow_o` are unaffected.
- **Reset:** asynchronous. `valid_o`=0, `data_o`=0, `overflow_o`=0, counter/accumulators/stage 1 cleared. `ready_o`=1 immediately after reset deasserts.

## Timing
- Last sample of a window accepted at edge t → `valid_o`=1 after edge t+2.
- Throughput is one sample per cycle whenever the result register is empty or draining.
- With the result still pending (`ready_i` low), input keeps streaming until the next window's last sample reaches stage 2. `ready_o` then drops in the following cycle and recovers the cycle `ready_i` is seen high.
- Result handshake and new result load in the same cycle: the new data loads and `valid_o` stays 1.
- `window_len_p`=1: every sample produces a result.
- Reset mid-window: the partial sum is discarded, with no spurious `valid_o`.

## Structure
- Package `window_mac_pkg`:
  - Saturating-add function (sum plus overflow bit).
  - Shift constant `frac_out_p-2*frac_in_p` helper.
- Sub-module `mac_lane`, generated `channels_p` times: stage-1 product register, accumulator, saturation, overflow flag, result slice.
- Top level holds the shared counter, `s1_valid`/`s1_last`, stall logic and `valid_o`.

## Test plan
- **Basic window:** `window_len_p`=4, both lanes a=b=12'h400 (0.5) for 4 samples, `ready_i`=1 → `data_o` lanes = 32'h0040_0000 (1.0), `overflow_o`=0, `valid_o` high for exactly 1 cycle, 2 cycles after the 4th accept.
- **Back-to-back windows:** 8 consecutive samples, lane0 a=12'h400, b=12'hC00 (-0.5) → two results of 32'hFFC0_0000, no bubble on `ready_o`.
- **Backpressure:** `ready_i`=0 across a window end, then 8 more samples → `ready_o` drops after the second window's last sample reaches stage 2. The first result holds stable. Raising `ready_i` drains both results in order.
- **Saturation:** `window_len_p`=1024, a=b=12'h800 (-1.0) → `data_o`=32'h7FFF_FFFF, `overflow_o`=1 for that lane, other lane unaffected.
- **clear_i:** pulse `clear_i` after 2 of 4 samples, then 4 samples of 0.5*0.5 → result 32'h0040_0000. The aborted partial sum never appears.
- **Async reset:** assert `reset_n_i` mid-window, off-edge → all outputs 0 immediately. After release, a fresh 4-sample window gives the basic-window result.
